// File: rtl/ub_write_ctrl.sv
// Unified Buffer write master: deskews SIZE skewed column psums into one row and issues one SIZE-wide write per row.
// Optional feature: define UB_WR_RELU_EN to clamp negative psums to zero before they reach the UB.
module ub_write_ctrl #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = 8 + 4 + 4 + $clog2(SIZE),
    parameter int ROWS              = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Start,
    input  logic [5:0]                          Base_Addr,
    input  logic                                Psum_Valid,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_0,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_1,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_2,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_3,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_4,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_5,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_6,
    input  logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_7,
    output logic                                Busy,
    output logic                                Done,
    output logic                                Wr_en,
    output logic [5:0]                          Wr_Addr,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_0,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_1,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_2,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_3,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_4,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_5,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_6,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data_7,
    output logic [1:0]                          fsm_state
);

    localparam int PSW = PARTIAL_SUM_WIDTH;
    localparam int CW  = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  issue;
    logic [SIZE-2:0]       vpipe;
    logic [CW-1:0]         acc_cnt;
    logic [CW-1:0]         wr_cnt;
    logic [5:0]            next_addr;
    logic signed [PSW-1:0] psum_in [SIZE];
    logic signed [PSW-1:0] aligned [SIZE];
    logic signed [PSW-1:0] wr_data [SIZE];

    function automatic logic signed [PSW-1:0] lane_out(input logic signed [PSW-1:0] v);
`ifdef UB_WR_RELU_EN
        return v[PSW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign psum_in[0] = Psum_In_0;
    assign psum_in[1] = Psum_In_1;
    assign psum_in[2] = Psum_In_2;
    assign psum_in[3] = Psum_In_3;
    assign psum_in[4] = Psum_In_4;
    assign psum_in[5] = Psum_In_5;
    assign psum_in[6] = Psum_In_6;
    assign psum_in[7] = Psum_In_7;

    // The last stage of the valid pipe marks the cycle in which every lane of the row is aligned.
    assign issue     = vpipe[SIZE-2];
    assign Busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: if (Start) state_nxt = S_RUN;
            S_RUN: begin
                accept = Psum_Valid && (acc_cnt < CW'(ROWS));
                if (issue && (wr_cnt == CW'(ROWS - 1))) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Column c waits SIZE-1-c cycles so it lines up with the undelayed last column.
    for (genvar c = 0; c < SIZE - 1; c++) begin : g_dly
        logic signed [PSW-1:0] line [SIZE-1-c];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < SIZE - 1 - c; k++) line[k] <= '0;
            end else begin
                line[0] <= psum_in[c];
                for (int k = 1; k < SIZE - 1 - c; k++) line[k] <= line[k-1];
            end
        end
        assign aligned[c] = line[SIZE-2-c];
    end
    assign aligned[SIZE-1] = psum_in[SIZE-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe     <= '0;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            next_addr <= '0;
            Done      <= 1'b0;
            Wr_en     <= 1'b0;
            Wr_Addr   <= '0;
            for (int c = 0; c < SIZE; c++) wr_data[c] <= '0;
        end else begin
            vpipe <= {vpipe[SIZE-3:0], accept};
            Done  <= (state == S_DONE);
            Wr_en <= issue;
            if (state == S_IDLE && Start) begin
                next_addr <= Base_Addr & 6'b111000;
                acc_cnt   <= '0;
                wr_cnt    <= '0;
            end else begin
                if (accept) acc_cnt <= acc_cnt + 1'b1;
                if (issue) begin
                    wr_cnt    <= wr_cnt + 1'b1;
                    next_addr <= next_addr + 6'(SIZE);
                end
            end
            if (issue) begin
                Wr_Addr <= next_addr;
                for (int c = 0; c < SIZE; c++) wr_data[c] <= lane_out(aligned[c]);
            end
        end
    end

    assign Wr_Data_0 = wr_data[0];
    assign Wr_Data_1 = wr_data[1];
    assign Wr_Data_2 = wr_data[2];
    assign Wr_Data_3 = wr_data[3];
    assign Wr_Data_4 = wr_data[4];
    assign Wr_Data_5 = wr_data[5];
    assign Wr_Data_6 = wr_data[6];
    assign Wr_Data_7 = wr_data[7];

endmodule
